// File: rtl/fsm_tbl_pkg.sv
// Shared types and constants for the table-driven Moore FSM and its self-test engine.
// entry_t documents the cfg_wdata layout at the default state and input widths.
package fsm_tbl_pkg;

    localparam int DEF_SW = 4;
    localparam int DEF_IW = 4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef struct packed {
        logic              valid;
        logic [DEF_SW-1:0] src;
        logic [DEF_IW-1:0] mask;
        logic [DEF_IW-1:0] val;
        logic [DEF_SW-1:0] dst;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // One right-shift Galois step, shared by the stimulus LFSR and the signature MISR.
    function automatic logic [15:0] galois_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/fsm_tbl_bist.sv
// Self-test engine: LFSR stimulus source, MISR signature over the visited states,
// step counter and the busy/done flags. Everything except the flags' reset is adv-gated.
module fsm_tbl_bist
    import fsm_tbl_pkg::*;
#(
    parameter int SW       = DEF_SW,
    parameter int IW       = DEF_IW,
    parameter int BIST_LEN = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv_i,
    input  logic          abort_i,
    input  logic          start_i,
    input  logic [SW-1:0] state_i,
    output logic [IW-1:0] lfsr_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [15:0]   sig_o
);

    localparam int            CW   = $clog2(BIST_LEN);
    localparam logic [CW-1:0] LAST = CW'(BIST_LEN - 1);

    logic [15:0]   lfsr_q, lfsr_d;
    logic [15:0]   misr_q, misr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_comb begin
        lfsr_d = lfsr_q;
        misr_d = misr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = done_q;
        if (adv_i) begin
            if (abort_i) begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end else if (start_i) begin
                lfsr_d = LFSR_SEED;
                misr_d = 16'h0000;
                cnt_d  = '0;
                busy_d = 1'b1;
                done_d = 1'b0;
            end else if (busy_q) begin
                // The signature folds in the state the step started from.
                misr_d = galois_step(misr_q) ^ 16'(state_i);
                lfsr_d = galois_step(lfsr_q);
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
            misr_q <= 16'h0000;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            misr_q <= misr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign lfsr_o = lfsr_q[IW-1:0];
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sig_o  = misr_q;

endmodule

// File: rtl/fsm_tbl_mur.sv
// Run-time programmable Moore FSM: NTRANS-entry match table, lowest-index priority,
// test-mode clock gating and an embedded BIST engine driving the match input.
module fsm_tbl_mur
    import fsm_tbl_pkg::*;
#(
    parameter int SW           = DEF_SW,
    parameter int IW           = DEF_IW,
    parameter int NTRANS       = 64,
    parameter int BIST_LEN     = 256,
    parameter int NOMATCH_HOLD = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IW-1:0]             sig_in,
    output logic [SW-1:0]             state_o,
    input  logic                      tmode_i,
    input  logic                      tmode_clk_en,
    input  logic                      start_bist,
    input  logic                      rst_state,
    input  logic                      cfg_we,
    input  logic [$clog2(NTRANS)-1:0] cfg_addr,
    input  logic [2*SW+2*IW:0]        cfg_wdata,
    output logic                      cfg_err,
    output logic                      bist_busy,
    output logic                      bist_done,
    output logic [15:0]               bist_sig
);

    localparam int AW        = $clog2(NTRANS);
    localparam int EW        = 2*SW + 2*IW + 1;
    localparam int VAL_LO    = SW;
    localparam int MASK_LO   = SW + IW;
    localparam int SRC_LO    = SW + 2*IW;
    localparam int VALID_BIT = 2*SW + 2*IW;

    logic                      adv;
    logic [IW-1:0]             bist_in;
    logic [IW-1:0]             match_in;
    logic                      wr_ok;
    logic [NTRANS-1:0]         hit;
    logic [SW-1:0]             next_state;

    logic [NTRANS-1:0][EW-1:0] tbl_q, tbl_d;
    logic [SW-1:0]             state_q, state_d;
    logic                      cfg_err_q, cfg_err_d;

    assign adv      = ~tmode_i | tmode_clk_en;
    assign match_in = bist_busy ? bist_in : sig_in;
    assign wr_ok    = cfg_we & ~bist_busy;

    fsm_tbl_bist #(
        .SW       (SW),
        .IW       (IW),
        .BIST_LEN (BIST_LEN)
    ) u_bist (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (adv),
        .abort_i (rst_state),
        .start_i (start_bist),
        .state_i (state_q),
        .lfsr_o  (bist_in),
        .busy_o  (bist_busy),
        .done_o  (bist_done),
        .sig_o   (bist_sig)
    );

    for (genvar gi = 0; gi < NTRANS; gi++) begin : g_entry
        logic          e_valid;
        logic [SW-1:0] e_src;
        logic [IW-1:0] e_mask;
        logic [IW-1:0] e_val;

        assign e_valid = tbl_q[gi][VALID_BIT];
        assign e_src   = tbl_q[gi][SRC_LO +: SW];
        assign e_mask  = tbl_q[gi][MASK_LO +: IW];
        assign e_val   = tbl_q[gi][VAL_LO +: IW];
        // Masked-out bits are don't-care on both the input and the stored value.
        assign hit[gi] = e_valid & (e_src == state_q) & (((match_in ^ e_val) & e_mask) == '0);
    end

    // Scan from the top so the lowest-index hit is the last assignment and wins.
    always_comb begin
        next_state = (NOMATCH_HOLD != 0) ? state_q : '0;
        for (int i = NTRANS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                next_state = tbl_q[i][SW-1:0];
            end
        end
    end

    always_comb begin
        tbl_d = tbl_q;
        for (int i = 0; i < NTRANS; i++) begin
            if (wr_ok && (cfg_addr == AW'(i))) begin
                tbl_d[i] = cfg_wdata;
            end
        end
    end

    // Table writes and the reject pulse are deliberately independent of adv.
    always_comb begin
        cfg_err_d = cfg_we & bist_busy;
        state_d   = state_q;
        if (adv) begin
            if (rst_state || start_bist) begin
                state_d = '0;
            end else begin
                state_d = next_state;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl_q     <= '0;
            state_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            tbl_q     <= tbl_d;
            state_q   <= state_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign state_o = state_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_fsm_tbl_mur.sv
// Bench for fsm_tbl_mur: two instances (no-match to zero / no-match hold) share stimulus;
// directed vectors and sequences first, then random traffic against a behavioural model.
module tb_fsm_tbl_mur;
    import fsm_tbl_pkg::*;

    localparam int NT = 64;
    localparam int BL = 256;

    logic        clk = 1'b0;
    logic        rst_n, tmode_i, tmode_clk_en, start_bist, rst_state, cfg_we;
    logic [3:0]  sig_in;
    logic [5:0]  cfg_addr;
    logic [16:0] cfg_wdata;
    logic [3:0]  st0, st1;
    logic        err0, err1, busy0, busy1, done0, done1;
    logic [15:0] sig0, sig1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fsm_tbl_mur #(.SW(4), .IW(4), .NTRANS(NT), .BIST_LEN(BL), .NOMATCH_HOLD(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .state_o(st0),
        .tmode_i(tmode_i), .tmode_clk_en(tmode_clk_en), .start_bist(start_bist),
        .rst_state(rst_state), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_err(err0), .bist_busy(busy0), .bist_done(done0), .bist_sig(sig0)
    );

    fsm_tbl_mur #(.SW(4), .IW(4), .NTRANS(NT), .BIST_LEN(BL), .NOMATCH_HOLD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .state_o(st1),
        .tmode_i(tmode_i), .tmode_clk_en(tmode_clk_en), .start_bist(start_bist),
        .rst_state(rst_state), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_err(err1), .bist_busy(busy1), .bist_done(done1), .bist_sig(sig1)
    );

    // Reference model: table as plain arrays, BIST as a countdown of remaining steps.
    logic        m_valid [NT];
    logic [3:0]  m_src   [NT];
    logic [3:0]  m_mask  [NT];
    logic [3:0]  m_val   [NT];
    logic [3:0]  m_dst   [NT];
    logic [3:0]  m_state [2];
    logic [15:0] m_misr  [2];
    logic [15:0] m_lfsr;
    logic        m_busy, m_done, m_err;
    int          m_left;

    typedef struct {
        logic       rs;
        logic [3:0] sig;
        logic [3:0] exp0;
        logic [3:0] exp1;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] x);
        return (x >> 1) ^ (((x & 16'h0001) != 16'h0000) ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [3:0] m_next(input int d, input logic [3:0] in);
        for (int i = 0; i < NT; i++) begin
            if (m_valid[i] && m_src[i] == m_state[d] && (in & m_mask[i]) == (m_val[i] & m_mask[i]))
                return m_dst[i];
        end
        return (d == 1) ? m_state[d] : 4'h0;
    endfunction

    // One clock: model predicts from pre-edge inputs, then outputs are sampled 1ns after the edge.
    task automatic tick();
        logic [3:0]  n_state [2];
        logic [15:0] n_misr  [2];
        logic [3:0]  nxt     [2];
        logic [15:0] n_lfsr;
        logic        n_busy, n_done, n_err, adv, do_wr;
        logic [3:0]  in;
        int          n_left;
        n_state = m_state;
        n_misr  = m_misr;
        n_lfsr  = m_lfsr;
        n_busy  = m_busy;
        n_done  = m_done;
        n_left  = m_left;
        adv     = !tmode_i || tmode_clk_en;
        in      = m_busy ? m_lfsr[3:0] : sig_in;
        n_err   = cfg_we && m_busy;
        do_wr   = cfg_we && !m_busy;
        for (int d = 0; d < 2; d++) nxt[d] = m_next(d, in);
        if (adv) begin
            if (rst_state) begin
                n_state = '{4'h0, 4'h0};
                n_busy  = 1'b0;
                n_done  = 1'b0;
            end else if (start_bist) begin
                n_state = '{4'h0, 4'h0};
                n_misr  = '{16'h0, 16'h0};
                n_lfsr  = 16'hACE1;
                n_left  = BL;
                n_busy  = 1'b1;
                n_done  = 1'b0;
            end else begin
                for (int d = 0; d < 2; d++) n_state[d] = nxt[d];
                if (m_busy) begin
                    for (int d = 0; d < 2; d++) n_misr[d] = lstep(m_misr[d]) ^ {12'h000, m_state[d]};
                    n_lfsr = lstep(m_lfsr);
                    n_left = m_left - 1;
                    if (n_left == 0) begin
                        n_busy = 1'b0;
                        n_done = 1'b1;
                    end
                end
            end
        end
        if (!rst_n) begin
            for (int i = 0; i < NT; i++) m_valid[i] = 1'b0;
            n_state = '{4'h0, 4'h0};
            n_misr  = '{16'h0, 16'h0};
            n_lfsr  = 16'hACE1;
            n_busy  = 1'b0;
            n_done  = 1'b0;
            n_err   = 1'b0;
            n_left  = 0;
        end else if (do_wr) begin
            m_valid[cfg_addr] = cfg_wdata[16];
            m_src[cfg_addr]   = cfg_wdata[15:12];
            m_mask[cfg_addr]  = cfg_wdata[11:8];
            m_val[cfg_addr]   = cfg_wdata[7:4];
            m_dst[cfg_addr]   = cfg_wdata[3:0];
        end
        @(posedge clk);
        #1;
        m_state = n_state;
        m_misr  = n_misr;
        m_lfsr  = n_lfsr;
        m_busy  = n_busy;
        m_done  = n_done;
        m_err   = n_err;
        m_left  = n_left;
    endtask

    task automatic cfg_write(input int addr, input logic v, input logic [3:0] s, m, vl, d);
        entry_t e;
        e.valid   = v;
        e.src     = s;
        e.mask    = m;
        e.val     = vl;
        e.dst     = d;
        cfg_we    = 1'b1;
        cfg_addr  = 6'(addr);
        cfg_wdata = e;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic chk_states(input string name, input logic [3:0] e0, input logic [3:0] e1);
        chk({name, " state0"}, st0, e0);
        chk({name, " state1"}, st1, e1);
    endtask

    task automatic model_check();
        chk("mdl state0", st0, m_state[0]);
        chk("mdl state1", st1, m_state[1]);
        chk("mdl busy0", busy0, m_busy);
        chk("mdl busy1", busy1, m_busy);
        chk("mdl done0", done0, m_done);
        chk("mdl done1", done1, m_done);
        chk("mdl sig0", sig0, m_misr[0]);
        chk("mdl sig1", sig1, m_misr[1]);
        chk("mdl err0", err0, m_err);
        chk("mdl err1", err1, m_err);
    endtask

    initial begin
        int n;
        vecs[0] = '{1'b0, 4'hF, 4'hD, 4'hD};
        vecs[1] = '{1'b0, 4'h0, 4'h0, 4'hD};
        vecs[2] = '{1'b1, 4'h0, 4'h0, 4'h0};
        vecs[3] = '{1'b0, 4'h1, 4'h2, 4'h2};
        vecs[4] = '{1'b0, 4'h1, 4'h0, 4'h2};
        vecs[5] = '{1'b1, 4'hF, 4'h0, 4'h0};
        vecs[6] = '{1'b0, 4'hE, 4'h0, 4'h0};
        vecs[7] = '{1'b0, 4'hF, 4'hD, 4'hD};

        for (int i = 0; i < NT; i++) begin
            m_valid[i] = 1'b0; m_src[i] = '0; m_mask[i] = '0; m_val[i] = '0; m_dst[i] = '0;
        end
        m_state = '{4'h0, 4'h0};
        m_misr  = '{16'h0, 16'h0};
        m_lfsr  = 16'hACE1;
        m_busy  = 1'b0; m_done = 1'b0; m_err = 1'b0; m_left = 0;

        rst_n = 1'b0; tmode_i = 1'b0; tmode_clk_en = 1'b0; start_bist = 1'b0;
        rst_state = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; sig_in = '0;
        tick();
        tick();
        chk_states("reset", 4'h0, 4'h0);
        chk("reset busy", busy0, 1'b0);
        chk("reset done", done0, 1'b0);
        chk("reset sig", sig0, 16'h0000);
        chk("reset cfg_err", err0, 1'b0);
        rst_n = 1'b1;
        $display("reset released");

        // Basic transitions, table-driven.
        tmode_i = 1'b1;
        cfg_write(0, 1'b1, 4'h0, 4'hF, 4'hF, 4'hD);
        cfg_write(1, 1'b1, 4'h0, 4'hE, 4'h0, 4'h2);
        tmode_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rst_state = vecs[i].rs;
            sig_in    = vecs[i].sig;
            tick();
            chk_states($sformatf("vec%0d", i), vecs[i].exp0, vecs[i].exp1);
            $display("vec %0d rs=%b sig=%h state=%h/%h", i, vecs[i].rs, vecs[i].sig, st0, st1);
        end
        rst_state = 1'b0;

        // Overlapping entries: lowest index wins, then the next one after invalidation.
        tmode_i = 1'b1;
        cfg_write(0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        cfg_write(1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        cfg_write(3, 1'b1, 4'h0, 4'h0, 4'h0, 4'h7);
        cfg_write(5, 1'b1, 4'h0, 4'h3, 4'h3, 4'h8);
        tmode_i = 1'b0;
        rst_state = 1'b1; tick(); rst_state = 1'b0;
        sig_in = 4'h3; tick();
        chk_states("overlap", 4'h7, 4'h7);
        tmode_i = 1'b1;
        cfg_write(3, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        tmode_i = 1'b0;
        rst_state = 1'b1; tick(); rst_state = 1'b0;
        tick();
        chk_states("overlap inval", 4'h8, 4'h8);
        $display("overlap state=%h/%h", st0, st1);

        // No-match behaviour from state 5 with an empty table.
        tmode_i = 1'b1;
        cfg_write(5, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        cfg_write(2, 1'b1, 4'h0, 4'h0, 4'h0, 4'h5);
        tmode_i = 1'b0;
        rst_state = 1'b1; tick(); rst_state = 1'b0;
        sig_in = 4'h0; tick();
        chk_states("to5", 4'h5, 4'h5);
        tmode_i = 1'b1;
        cfg_write(2, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        chk_states("frozen5", 4'h5, 4'h5);
        tmode_i = 1'b0;
        tick();
        chk_states("nomatch", 4'h0, 4'h5);
        $display("nomatch state=%h/%h", st0, st1);

        // Test-mode gating: ten frozen cycles, then exactly one transition.
        tmode_i = 1'b1;
        cfg_write(6, 1'b1, 4'h0, 4'h0, 4'h0, 4'h3);
        tmode_i = 1'b0;
        rst_state = 1'b1; tick(); rst_state = 1'b0;
        tmode_i = 1'b1; tmode_clk_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_states($sformatf("tfreeze%0d", i), 4'h0, 4'h0);
        end
        tmode_clk_en = 1'b1; tick(); tmode_clk_en = 1'b0;
        chk_states("tstep", 4'h3, 4'h3);
        tick();
        chk_states("tstep hold", 4'h3, 4'h3);
        cfg_write(6, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        tmode_i = 1'b0;
        $display("tmode state=%h/%h", st0, st1);

        // Full BIST on an empty table, with a rejected write mid-run.
        sig_in = 4'hF;
        start_bist = 1'b1; tick(); start_bist = 1'b0;
        chk("bist start busy", busy0, 1'b1);
        chk("bist start done", done0, 1'b0);
        chk_states("bist start", 4'h0, 4'h0);
        n = 1;
        for (int c = 0; c < 400 && busy0 === 1'b1; c++) begin
            if (c == 50) begin
                cfg_we = 1'b1; cfg_addr = 6'd9; cfg_wdata = 17'h1000F;
            end
            tick();
            cfg_we = 1'b0;
            if (c == 50) chk("bist cfg_err pulse", err0, 1'b1);
            if (c == 51) chk("bist cfg_err clear", err0, 1'b0);
            if (busy0 === 1'b1) n++;
        end
        chk("bist busy cycles", n, BL);
        chk("bist done", done0, 1'b1);
        chk("bist sig0", sig0, 16'h0000);
        chk("bist sig1", sig1, 16'h0000);
        sig_in = 4'h0; tick();
        chk_states("bist table unchanged", 4'h0, 4'h0);
        chk("bist done sticky", done0, 1'b1);
        $display("bist busy_cycles=%0d sig=%h done=%b", n, sig0, done0);

        // Reset in the middle of a BIST run, then rst_state abort.
        tmode_i = 1'b1;
        cfg_write(4, 1'b1, 4'h0, 4'h0, 4'h0, 4'h1);
        tmode_i = 1'b0;
        start_bist = 1'b1; tick(); start_bist = 1'b0;
        for (int i = 0; i < 99; i++) tick();
        chk("midbist busy", busy0, 1'b1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("rstn busy", busy0, 1'b0);
        chk("rstn done", done0, 1'b0);
        chk("rstn sig0", sig0, 16'h0000);
        chk("rstn sig1", sig1, 16'h0000);
        chk_states("rstn", 4'h0, 4'h0);
        tick();
        chk_states("rstn table empty", 4'h0, 4'h0);
        start_bist = 1'b1; tick(); start_bist = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        rst_state = 1'b1; tick(); rst_state = 1'b0;
        chk("abort busy", busy0, 1'b0);
        chk("abort done", done0, 1'b0);
        chk_states("abort", 4'h0, 4'h0);
        $display("abort state=%h busy=%b", st0, busy0);

        // Random traffic against the model.
        for (int t = 0; t < 1200; t++) begin
            rst_n        = ($urandom_range(0, 999) >= 3);
            rst_state    = ($urandom_range(0, 99) == 0);
            start_bist   = ($urandom_range(0, 299) == 0);
            tmode_i      = ($urandom_range(0, 4) == 0);
            tmode_clk_en = $urandom_range(0, 1) == 1;
            sig_in       = 4'($urandom_range(0, 15));
            cfg_we       = ($urandom_range(0, 9) == 0);
            cfg_addr     = 6'($urandom_range(0, 7));
            cfg_wdata    = {($urandom_range(0, 3) != 0),
                            4'($urandom_range(0, 1) == 1 ? $urandom_range(0, 3) : $urandom_range(0, 15)),
                            4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                            4'($urandom_range(0, 15)),
                            4'($urandom_range(0, 15))};
            tick();
            model_check();
            $display("rnd %0d st=%h/%h busy=%b done=%b sig=%h/%h err=%b",
                     t, st0, st1, busy0, done0, sig0, sig1, err0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
